// File: rtl/dmrs_ls_estimator.sv
// DM-RS least-squares channel estimator: H = Y * conj(X), rounded and saturated.
// Reference samples wait in a small FIFO until the matching received sample arrives.
module dmrs_ls_estimator #(
    parameter int RX_W       = 12,
    parameter int REF_W      = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [9:0]       Mzc,
    input  logic [REF_W-1:0] ref_r,
    input  logic [REF_W-1:0] ref_i,
    input  logic             ref_valid,
    input  logic [RX_W-1:0]  rx_r,
    input  logic [RX_W-1:0]  rx_i,
    input  logic             rx_valid,
    output logic [RX_W-1:0]  est_r,
    output logic [RX_W-1:0]  est_i,
    output logic             est_valid,
    output logic             est_last,
    output logic             done,
    output logic             busy,
    output logic             ovf_err,
    output logic             udf_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = RX_W + REF_W;
    localparam int SW = PW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [AW:0]          CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [SW-1:0] RND      = SW'(64);

    logic [1:0]         state;
    logic [9:0]         mzc_q;
    logic [9:0]         ref_cnt;
    logic [9:0]         rx_cnt;
    logic [9:0]         out_cnt;
    logic [2*REF_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      wr_addr;
    logic [AW:0]        count;

    logic start_cyc;
    logic fifo_full;
    logic fifo_empty;
    logic ref_take;
    logic push;
    logic pop;
    logic ovf_ev;
    logic udf_ev;
    logic rx_final;

    logic [REF_W-1:0]     h_r;
    logic [REF_W-1:0]     h_i;
    logic signed [PW-1:0] a_r;
    logic signed [PW-1:0] a_i;
    logic signed [PW-1:0] b_r;
    logic signed [PW-1:0] b_i;

    logic signed [PW-1:0] p_rr;
    logic signed [PW-1:0] p_ii;
    logic signed [PW-1:0] p_ir;
    logic signed [PW-1:0] p_ri;
    logic                 s1_valid;
    logic                 s1_last;

    logic signed [SW-1:0] sum_r;
    logic signed [SW-1:0] sum_i;

    assign start_cyc  = (state == IDLE) && start;
    assign fifo_full  = (count == CNT_FULL);
    assign fifo_empty = (count == '0);

    // The start cycle pushes into a FIFO that is being cleared at the same edge.
    assign ref_take = ref_valid &&
        (start_cyc ? (Mzc != 10'd0)
                   : ((state == RUN) && (ref_cnt < mzc_q)));

    assign pop      = (state == RUN) && rx_valid && !fifo_empty;
    assign udf_ev   = (state == RUN) && rx_valid && fifo_empty;
    assign push     = ref_take && (start_cyc || !fifo_full || pop);
    assign ovf_ev   = ref_take && !start_cyc && fifo_full && !pop;
    assign rx_final = pop && ((rx_cnt + 10'd1) == mzc_q);
    assign wr_addr  = start_cyc ? '0 : wr_ptr;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_addr] <= {ref_r, ref_i};
        end
    end

    assign {h_r, h_i} = mem[rd_ptr];

    assign a_r = $signed({{REF_W{rx_r[RX_W-1]}}, rx_r});
    assign a_i = $signed({{REF_W{rx_i[RX_W-1]}}, rx_i});
    assign b_r = $signed({{RX_W{h_r[REF_W-1]}}, h_r});
    assign b_i = $signed({{RX_W{h_i[REF_W-1]}}, h_i});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mzc_q   <= '0;
            ref_cnt <= '0;
            rx_cnt  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (state == DRAIN) && !s1_valid;
            if (start_cyc) begin
                mzc_q   <= Mzc;
                ref_cnt <= ref_take ? 10'd1 : 10'd0;
                rx_cnt  <= '0;
                rd_ptr  <= '0;
                wr_ptr  <= AW'(push);
                count   <= (AW+1)'(push);
                ovf_err <= 1'b0;
                udf_err <= 1'b0;
                state   <= (Mzc == 10'd0) ? DRAIN : RUN;
            end else begin
                if (ref_take) begin
                    ref_cnt <= ref_cnt + 10'd1;
                end
                if (pop) begin
                    rx_cnt <= rx_cnt + 10'd1;
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
                if (ovf_ev) begin
                    ovf_err <= 1'b1;
                end
                if (udf_ev) begin
                    udf_err <= 1'b1;
                end
                case (state)
                    RUN: begin
                        if (rx_final) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (!s1_valid) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_rr     <= '0;
            p_ii     <= '0;
            p_ir     <= '0;
            p_ri     <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
        end else begin
            s1_valid <= pop;
            s1_last  <= rx_final;
            if (pop) begin
                p_rr <= a_r * b_r;
                p_ii <= a_i * b_i;
                p_ir <= a_i * b_r;
                p_ri <= a_r * b_i;
            end
        end
    end

    assign sum_r = $signed({p_rr[PW-1], p_rr}) +
                   $signed({p_ii[PW-1], p_ii}) + RND;
    assign sum_i = $signed({p_ir[PW-1], p_ir}) -
                   $signed({p_ri[PW-1], p_ri}) + RND;

    // Shift out the Q2.7 fraction, then clamp into the sample range.
    function automatic logic [RX_W-1:0] rnd_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] sh;
        sh = s >>> 7;
        if ((&sh[SW-1:RX_W-1]) || !(|sh[SW-1:RX_W-1])) begin
            return sh[RX_W-1:0];
        end else if (sh[SW-1]) begin
            return {1'b1, {(RX_W-1){1'b0}}};
        end else begin
            return {1'b0, {(RX_W-1){1'b1}}};
        end
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            est_r     <= '0;
            est_i     <= '0;
            est_valid <= 1'b0;
            est_last  <= 1'b0;
            out_cnt   <= '0;
        end else begin
            est_valid <= s1_valid;
            est_last  <= s1_valid && s1_last;
            if (s1_valid) begin
                est_r <= rnd_sat(sum_r);
                est_i <= rnd_sat(sum_i);
            end
            if (start_cyc) begin
                out_cnt <= '0;
            end else if (s1_valid) begin
                out_cnt <= out_cnt + 10'd1;
            end
        end
    end

endmodule
